// File: rtl/draw_ball.sv
// Ball draw stage: owns the penalty-kick ball, animates its flight, judges the save, overlays it on the pixel stream.
// Optional DRAW_BALL_ROUND_EN draws the ball as a disc instead of a square box.
module draw_ball #(
  parameter int          BALL_SIZE   = 32,
  parameter int          START_X     = 496,
  parameter int          START_Y     = 640,
  parameter int          FLIGHT_LOG2 = 5,
  parameter int          HOLD_FRAMES = 60,
  parameter int          GLOVE_W     = 64,
  parameter int          GLOVE_H     = 64,
  parameter logic [11:0] BALL_COLOR  = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        shot_start,
  input  logic [11:0] target_x,
  input  logic [11:0] target_y,
  input  logic [11:0] glove_x,
  input  logic [11:0] glove_y,
  input  logic [10:0] in_hcount,
  input  logic [10:0] in_vcount,
  input  logic        in_hsync,
  input  logic        in_vsync,
  input  logic        in_hblnk,
  input  logic        in_vblnk,
  input  logic [11:0] in_rgb,
  output logic [10:0] out_hcount,
  output logic [10:0] out_vcount,
  output logic        out_hsync,
  output logic        out_vsync,
  output logic        out_hblnk,
  output logic        out_vblnk,
  output logic [11:0] out_rgb,
  output logic        busy,
  output logic        result_valid,
  output logic        result_save
);

  localparam int          PROD_W   = 13 + FLIGHT_LOG2 + 2;
  localparam logic [15:0] FLIGHT_N = 16'(1 << FLIGHT_LOG2);
  localparam logic [15:0] HOLD_END = 16'(HOLD_FRAMES - 1);
  localparam logic [11:0] MAX_X    = 12'(1024 - BALL_SIZE);
  localparam logic [11:0] MAX_Y    = 12'(768 - BALL_SIZE);
  localparam logic [11:0] START_X12 = 12'(START_X);
  localparam logic [11:0] START_Y12 = 12'(START_Y);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLIGHT = 2'd1,
    JUDGE  = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] cnt_r, cnt_s, cnt_inc_s;
  logic [11:0] tx_r, tx_s, ty_r, ty_s;
  logic [11:0] bx_r, bx_s, by_r, by_s;
  logic        vsync_r;
  logic        tick_s;
  logic        rv_s, rs_s;
  logic        in_box_s, ball_px_s;

  // Linear interpolation start -> tgt at step cnt out of 2^FLIGHT_LOG2, floor-rounded.
  function automatic logic [11:0] fly(input logic [11:0] start, input logic [11:0] tgt,
                                      input logic [15:0] cnt);
    logic signed [12:0]       delta;
    logic signed [PROD_W-1:0] d_w, c_w, prod, sum;
    delta = $signed({1'b0, tgt}) - $signed({1'b0, start});
    d_w   = PROD_W'(delta);
    c_w   = PROD_W'($signed({1'b0, cnt[FLIGHT_LOG2:0]}));
    prod  = d_w * c_w;
    sum   = PROD_W'($signed({1'b0, start})) + (prod >>> FLIGHT_LOG2);
    return sum[11:0];
  endfunction

  // Box overlap, widened by one bit so the sums never wrap.
  function automatic logic overlap(input logic [11:0] bx, input logic [11:0] by,
                                   input logic [11:0] gx, input logic [11:0] gy);
    logic [12:0] bx_w, by_w, gx_w, gy_w;
    bx_w = {1'b0, bx};
    by_w = {1'b0, by};
    gx_w = {1'b0, gx};
    gy_w = {1'b0, gy};
    return (bx_w < gx_w + 13'(GLOVE_W)) && (gx_w < bx_w + 13'(BALL_SIZE)) &&
           (by_w < gy_w + 13'(GLOVE_H)) && (gy_w < by_w + 13'(BALL_SIZE));
  endfunction

  assign tick_s    = in_vsync & ~vsync_r;
  assign cnt_inc_s = cnt_r + 16'd1;

  // Shot FSM: next state, counter, target latch and ball position.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    tx_s    = tx_r;
    ty_s    = ty_r;
    bx_s    = bx_r;
    by_s    = by_r;
    rv_s    = 1'b0;
    rs_s    = result_save;
    case (state_r)
      IDLE: begin
        bx_s = START_X12;
        by_s = START_Y12;
        if (shot_start) begin
          state_s = FLIGHT;
          cnt_s   = 16'd0;
          tx_s    = (target_x > MAX_X) ? MAX_X : target_x;
          ty_s    = (target_y > MAX_Y) ? MAX_Y : target_y;
        end else begin
          state_s = IDLE;
        end
      end
      FLIGHT: begin
        if (cnt_r == FLIGHT_N) begin
          state_s = JUDGE;
        end else if (tick_s) begin
          cnt_s = cnt_inc_s;
          bx_s  = fly(START_X12, tx_r, cnt_inc_s);
          by_s  = fly(START_Y12, ty_r, cnt_inc_s);
        end else begin
          state_s = FLIGHT;
        end
      end
      JUDGE: begin
        rv_s    = 1'b1;
        rs_s    = overlap(bx_r, by_r, glove_x, glove_y);
        state_s = HOLD;
        cnt_s   = 16'd0;
      end
      HOLD: begin
        if (tick_s) begin
          if (cnt_r == HOLD_END) begin
            state_s = IDLE;
            cnt_s   = 16'd0;
            bx_s    = START_X12;
            by_s    = START_Y12;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign in_box_s = ({2'b00, in_hcount} >= {1'b0, bx_r}) &&
                    ({2'b00, in_hcount} <  {1'b0, bx_r} + 13'(BALL_SIZE)) &&
                    ({2'b00, in_vcount} >= {1'b0, by_r}) &&
                    ({2'b00, in_vcount} <  {1'b0, by_r} + 13'(BALL_SIZE));

`ifdef DRAW_BALL_ROUND_EN
  logic [11:0]        dx_s, dy_s;
  logic signed [13:0] ex_s, ey_s;
  logic signed [27:0] r2_s;
  logic               disc_s;

  assign dx_s   = {1'b0, in_hcount} - bx_r;
  assign dy_s   = {1'b0, in_vcount} - by_r;
  // (2d+1-BALL_SIZE) measures the offset from the box centre in half pixels.
  assign ex_s   = $signed({1'b0, dx_s, 1'b1}) - $signed(14'(BALL_SIZE));
  assign ey_s   = $signed({1'b0, dy_s, 1'b1}) - $signed(14'(BALL_SIZE));
  assign r2_s   = (28'(ex_s) * 28'(ex_s)) + (28'(ey_s) * 28'(ey_s));
  assign disc_s = (r2_s <= $signed(28'(BALL_SIZE * BALL_SIZE)));
`endif

  // Pixel selection: ball colour only inside the visible ball shape.
  always_comb begin
    ball_px_s = 1'b0;
    if (in_box_s && !in_hblnk && !in_vblnk) begin
`ifdef DRAW_BALL_ROUND_EN
      ball_px_s = disc_s;
`else
      ball_px_s = 1'b1;
`endif
    end else begin
      ball_px_s = 1'b0;
    end
  end

  // State, ball and registered pixel/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= 16'd0;
      tx_r         <= START_X12;
      ty_r         <= START_Y12;
      bx_r         <= START_X12;
      by_r         <= START_Y12;
      vsync_r      <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_save  <= 1'b0;
      out_hcount   <= 11'd0;
      out_vcount   <= 11'd0;
      out_hsync    <= 1'b0;
      out_vsync    <= 1'b0;
      out_hblnk    <= 1'b0;
      out_vblnk    <= 1'b0;
      out_rgb      <= 12'h000;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      tx_r         <= tx_s;
      ty_r         <= ty_s;
      bx_r         <= bx_s;
      by_r         <= by_s;
      vsync_r      <= in_vsync;
      busy         <= (state_s != IDLE);
      result_valid <= rv_s;
      result_save  <= rs_s;
      out_hcount   <= in_hcount;
      out_vcount   <= in_vcount;
      out_hsync    <= in_hsync;
      out_vsync    <= in_vsync;
      out_hblnk    <= in_hblnk;
      out_vblnk    <= in_vblnk;
      out_rgb      <= ball_px_s ? BALL_COLOR : in_rgb;
    end
  end

endmodule

// File: tb/tb_draw_ball.sv
// Scoreboard bench for draw_ball: directed shots, pixel probes and result strobes checked by a separate monitor.
module tb_draw_ball;

  localparam logic [11:0] BG = 12'h0A0;
  localparam logic [11:0] BC = 12'hFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        shot_start = 1'b0;
  logic [11:0] target_x = 12'd0, target_y = 12'd0;
  logic [11:0] glove_x = 12'd600, glove_y = 12'd100;
  logic [10:0] in_hcount = 11'd500, in_vcount = 11'd650;
  logic        in_hsync = 1'b1, in_vsync = 1'b0, in_hblnk = 1'b0, in_vblnk = 1'b0;
  logic [11:0] in_rgb = BG;
  logic [10:0] out_hcount, out_vcount;
  logic        out_hsync, out_vsync, out_hblnk, out_vblnk;
  logic [11:0] out_rgb;
  logic        busy, result_valid, result_save;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
  } pix_t;

  pix_t pix_q[$];
  logic res_q[$];
  logic probe_s = 1'b0;
  logic probe_d = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  draw_ball dut (
    .clk(clk), .rst(rst), .shot_start(shot_start),
    .target_x(target_x), .target_y(target_y), .glove_x(glove_x), .glove_y(glove_y),
    .in_hcount(in_hcount), .in_vcount(in_vcount), .in_hsync(in_hsync), .in_vsync(in_vsync),
    .in_hblnk(in_hblnk), .in_vblnk(in_vblnk), .in_rgb(in_rgb),
    .out_hcount(out_hcount), .out_vcount(out_vcount), .out_hsync(out_hsync),
    .out_vsync(out_vsync), .out_hblnk(out_hblnk), .out_vblnk(out_vblnk), .out_rgb(out_rgb),
    .busy(busy), .result_valid(result_valid), .result_save(result_save)
  );

  always #5 clk = ~clk;

  always @(posedge clk) probe_d <= probe_s;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Monitor: pops expected pixels and results whenever the DUT presents them.
  always @(negedge clk) begin
    if (!rst) begin
      if (probe_d) begin
        if (pix_q.size() == 0) check("pix_unexpected", 64'd1, 64'd0);
        else check("pixel", {out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk,
                             out_vblnk, out_rgb}, pix_q.pop_front());
      end
      if (result_valid) begin
        if (res_q.size() == 0) check("result_unexpected", 64'd1, 64'd0);
        else check("result_save", {63'd0, result_save}, {63'd0, res_q.pop_front()});
      end
    end
  end

  task automatic drive(input int h, input int v, input logic hs, input logic vs,
                       input logic hb, input logic vb, input logic [11:0] exp_rgb);
    pix_t e;
    in_hcount = 11'(h);
    in_vcount = 11'(v);
    in_hsync  = hs;
    in_vsync  = vs;
    in_hblnk  = hb;
    in_vblnk  = vb;
    in_rgb    = BG;
    probe_s   = 1'b1;
    e = '{h: 11'(h), v: 11'(v), hs: hs, vs: vs, hb: hb, vb: vb, rgb: exp_rgb};
    pix_q.push_back(e);
    @(posedge clk); #1;
    probe_s    = 1'b0;
    shot_start = 1'b0;
    in_vsync   = 1'b0;
    in_hblnk   = 1'b1;
    in_vblnk   = 1'b1;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      shot_start = 1'b0;
    end
  endtask

  task automatic probe(input int h, input int v, input logic [11:0] exp_rgb);
    drive(h, v, h[0], 1'b0, 1'b0, 1'b0, exp_rgb);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      drive(0, 770, 1'b1, 1'b1, 1'b1, 1'b1, BG);
      cyc(3);
    end
  endtask

  task automatic ball_at(input int bx, input int by);
    probe(bx + 16, by + 16, BC);
    probe(bx,      by + 16, BC);
    probe(bx - 1,  by + 16, BG);
    probe(bx + 31, by + 16, BC);
    probe(bx + 32, by + 16, BG);
    probe(bx + 16, by - 1,  BG);
    probe(bx + 16, by + 31, BC);
    probe(bx + 16, by + 32, BG);
`ifdef DRAW_BALL_ROUND_EN
    probe(bx, by, BG);
`else
    probe(bx, by, BC);
`endif
  endtask

  task automatic check_busy(input string name, input logic exp);
    @(negedge clk);
    check(name, {63'd0, busy}, {63'd0, exp});
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outs(input string name);
    @(negedge clk);
    check(name, {out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk,
                 out_rgb, busy, result_valid, result_save}, 64'd0);
  endtask

  task automatic shot(input int tx, input int ty, input bit expect_result, input logic save);
    target_x   = 12'(tx);
    target_y   = 12'(ty);
    shot_start = 1'b1;
    if (expect_result) res_q.push_back(save);
    cyc(1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 2000000", $time);
    $fatal(1);
  end

  initial begin
    // Reset with busy-looking inputs: everything must read zero.
    cyc(3);
    check_reset_outs("reset_outputs");
    @(posedge clk); #1;
    rst = 1'b0;
    tick(2);
    probe(500, 650, BC);
    probe(400, 650, BG);
    drive(500, 650, 1'b0, 1'b0, 1'b1, 1'b0, BG);
    ball_at(496, 640);
    check_busy("busy_idle", 1'b0);

    // Shot 1: glove far away, goal.
    glove_x = 12'd600; glove_y = 12'd100;
    shot(200, 100, 1'b1, 1'b0);
    cyc(1);
    check_busy("busy_rise", 1'b1);
    tick(16);
    ball_at(348, 370);
    tick(16);
    check("result1_seen", 64'(res_q.size()), 64'd0);
    ball_at(200, 100);
    tick(59);
    check_busy("busy_hold59", 1'b1);
    ball_at(200, 100);
    tick(1);
    check_busy("busy_hold_end", 1'b0);
    ball_at(496, 640);

    // Shot 2: glove covers the target, save.
    glove_x = 12'd180; glove_y = 12'd90;
    shot(200, 100, 1'b1, 1'b1);
    tick(32);
    check("result2_seen", 64'(res_q.size()), 64'd0);
    tick(60);
    check_busy("busy_after2", 1'b0);
    ball_at(496, 640);

    // Shot 3: second kick mid-flight is dropped.
    glove_x = 12'd600; glove_y = 12'd100;
    shot(200, 100, 1'b1, 1'b0);
    tick(10);
    shot(700, 700, 1'b0, 1'b0);
    tick(6);
    ball_at(348, 370);
    tick(16);
    check("result3_seen", 64'(res_q.size()), 64'd0);
    ball_at(200, 100);
    tick(60);
    check_busy("busy_after3", 1'b0);

    // Shot 4: kick on the tick itself; first move only on the next tick.
    target_x   = 12'd200;
    target_y   = 12'd100;
    shot_start = 1'b1;
    tick(1);
    check_busy("busy_shot_on_tick", 1'b1);
    ball_at(496, 640);
    tick(1);
    probe(511, 639, BC);
    probe(518, 639, BG);
    probe(485, 639, BG);
    tick(19);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outs("reset_midflight");
    @(posedge clk); #1;
    rst = 1'b0;
    tick(40);
    check_busy("busy_after_reset", 1'b0);
    ball_at(496, 640);

    // Clamped target: 1000,750 flies to 992,736.
    glove_x = 12'd0; glove_y = 12'd0;
    shot(1000, 750, 1'b1, 1'b0);
    tick(32);
    check("result5_seen", 64'(res_q.size()), 64'd0);
    ball_at(992, 720 + 16);
    cyc(4);

    check("pix_queue_drained", 64'(pix_q.size()), 64'd0);
    check("res_queue_drained", 64'(res_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
